// File: rtl/alarm_sequencer.sv
// Alarm tone sequencer: plays grouped ON/OFF beeps with a gap between groups
// after countdown expiry, until user acknowledge or the group limit is reached.
module alarm_sequencer #(
  parameter int TICK_DIV   = 5000,
  parameter int ON_MS      = 200,
  parameter int OFF_MS     = 150,
  parameter int GAP_MS     = 1000,
  parameter int BEEPS      = 4,
  parameter int MAX_GROUPS = 30
) (
  input  logic       pulse_5MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] mode_sel,
  output logic [2:0] audioselection,
  output logic       audio_en,
  output logic       busy,
  output logic       done,
  output logic       timed_out
);
  // state | meaning
  // IDLE  | quiet, waiting for start
  // ON    | beep sounding
  // OFF   | silence between beeps of a group
  // GAP   | silence between groups
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  localparam int MAX_MS = (ON_MS > OFF_MS) ? ((ON_MS > GAP_MS) ? ON_MS : GAP_MS)
                                           : ((OFF_MS > GAP_MS) ? OFF_MS : GAP_MS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
  localparam int BW = $clog2(BEEPS + 1);
  localparam int GW = $clog2(MAX_GROUPS + 1);

  localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_MS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_MS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_MS - 1);
  localparam logic [BW-1:0] BEEPS_L  = BW'(BEEPS);
  localparam logic [GW-1:0] GROUPS_L = GW'(MAX_GROUPS);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [GW-1:0] group_q, group_d;
  logic [2:0]    mode_q, mode_d;
  logic [2:0]    sel_q, sel_d;
  logic          audio_en_q, audio_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timed_out_q, timed_out_d;

  logic          tick_evt;
  logic [BW-1:0] beep_inc;
  logic [GW-1:0] group_inc;
  logic [2:0]    mode_map;
  logic [31:0]   grp_wide;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    beep_d      = beep_q;
    group_d     = group_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    timed_out_d = timed_out_q;
    done_d      = 1'b0;
    tick_evt    = (presc_q == P_LAST);
    beep_inc    = beep_q + BW'(1);
    group_inc   = group_q + GW'(1);
    mode_map    = (mode_sel > 3'd5) ? 3'd0 : mode_sel;
    grp_wide    = 32'(group_inc);

    // stop outranks any timer expiry landing in the same cycle
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_d     = S_ON;
            mode_d      = mode_map;
            sel_d       = (mode_map == 3'd5) ? 3'd0 : mode_map;
            timed_out_d = 1'b0;
            beep_d      = '0;
            group_d     = '0;
          end
        end
        S_ON: begin
          if (tick_evt && tick_q == ON_LAST) begin
            beep_d  = beep_inc;
            state_d = (beep_inc == BEEPS_L) ? S_GAP : S_OFF;
          end
        end
        S_OFF: begin
          if (tick_evt && tick_q == OFF_LAST) state_d = S_ON;
        end
        S_GAP: begin
          if (tick_evt && tick_q == GAP_LAST) begin
            group_d = group_inc;
            beep_d  = '0;
            if (group_inc == GROUPS_L) begin
              state_d     = S_IDLE;
              timed_out_d = 1'b1;
              done_d      = 1'b1;
            end else begin
              state_d = S_ON;
              if (mode_q == 3'd5) sel_d = 3'(grp_wide % 32'd5);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // prescaler and tick counter restart on every state entry
    if (state_d != state_q) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (state_q != S_IDLE) begin
      if (tick_evt) begin
        presc_d = '0;
        tick_d  = tick_q + TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    audio_en_d = (state_d == S_ON);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge pulse_5MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tick_q      <= '0;
      beep_q      <= '0;
      group_q     <= '0;
      mode_q      <= '0;
      sel_q       <= '0;
      audio_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      beep_q      <= beep_d;
      group_q     <= group_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      audio_en_q  <= audio_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign audioselection = sel_q;
  assign audio_en       = audio_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timed_out      = timed_out_q;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the egg-timer alarm tone generator when a countdown expires. On a start request, it drives the tone generator's 3-bit tone selection and an audio enable through a beep cadence: ON/OFF beeps grouped into bursts, with a gap between groups. It stops on user acknowledge or after a fixed number of groups. It sits between the countdown/control FSM and the tone generator; `audio_en` gates the PWM output.

## Interface
- `TICK_DIV`, default 5000: clock cycles per 1 ms tick (5 MHz clock).
- `ON_MS`, default 200: beep-on duration in ticks, ≥1.
- `OFF_MS`, default 150: silence between beeps in a group, in ticks, ≥1.
- `GAP_MS`, default 1000: silence between groups, in ticks, ≥1.
- `BEEPS`, default 4: beeps per group, ≥1.
- `MAX_GROUPS`, default 30: groups before auto-timeout, ≥1.
- `pulse_5MHz`  in  1  clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; countdown expired.
- `stop`  in  1  single-cycle user acknowledge.
- `mode_sel`  in  3  requested pattern; sampled only on accepted `start`.
- `audioselection`  out  3  tone selection to the tone generator.
- `audio_en`  out  1  1 = tone audible.
- `busy`  out  1  1 while not IDLE.
- `done`  out  1  single-cycle pulse when a sequence ends.
- `timed_out`  out  1  sticky; set on auto-timeout, cleared on next accepted `start`.

## Operation
- States:
  - IDLE: quiet, waiting for `start`.
  - ON: beep sounding.
  - OFF: silence between beeps in a group.
  - GAP: silence between groups.
- Counters:
  - A ms prescaler counts 0..TICK_DIV-1. It is cleared on entry to every state.
  - A tick counter counts ms ticks within the current state.
  - A beep counter uses width $clog2(BEEPS+1). A group counter uses width $clog2(MAX_GROUPS+1).
- IDLE:
  - `start`=1 and `stop`=0 → ON. In the same cycle: latch `mode_sel`, clear `timed_out`, zero the beep and group counters.
- ON: after ON_MS ticks, increment the beep counter.
  - Beep count < BEEPS → OFF.
  - Beep count = BEEPS → GAP.
- OFF: after OFF_MS ticks → ON.
- GAP: after GAP_MS ticks, increment the group counter and zero the beep counter.
  - Group count = MAX_GROUPS → IDLE, with `timed_out`=1 and `done` pulsed.
  - Otherwise → ON.
- `stop` in ON, OFF or GAP → IDLE next cycle, with `done` pulsed and `timed_out` unchanged. `stop` has priority over every timer expiry in the same cycle.
- `start` while busy is ignored. `start` and `stop` together in IDLE are ignored. `stop` in IDLE has no effect.
- Pattern mapping from the latched mode:
  - Modes 0–4: `audioselection` = mode, constant for the whole sequence.
  - Mode 5 (cycle): `audioselection` = group count mod 5, so it steps 0,1,2,3,4,0… at each GAP→ON transition.
  - Modes 6 and 7: treated as mode 0.
- `audioselection` changes only at the GAP→ON transition or on start, so the tone never changes mid-beep. It holds its last value in IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - `audioselection`=0, `audio_en`=0, `busy`=0, `done`=0, `timed_out`=0.
  - All counters are 0.
- All outputs are registered.
- Start latency: `start` sampled at edge N. At edge N+1, `busy`=1, `audio_en`=1, and `audioselection` is valid.
- `audio_en`=1 exactly in ON. Each ON lasts ON_MS×TICK_DIV cycles, OFF lasts OFF_MS×TICK_DIV cycles, and GAP lasts GAP_MS×TICK_DIV cycles.
- Timeout: a full sequence lasts MAX_GROUPS×(BEEPS×ON_MS + (BEEPS−1)×OFF_MS + GAP_MS)×TICK_DIV cycles from the first ON cycle to the cycle `done` is asserted.
- Stop latency: `stop` sampled at edge N. At edge N+1, `audio_en`=0, `busy`=0, `done`=1. At edge N+2, `done`=0.
- Asserting `reset` mid-sequence forces the reset values immediately, without waiting for a clock edge. No `done` pulse is generated.
- A new `start` is accepted in the cycle after `done` (state is IDLE).

## Test plan
Bench parameters: TICK_DIV=4, ON_MS=2, OFF_MS=1, GAP_MS=3, BEEPS=2, MAX_GROUPS=2.
- Reset, then `start` with `mode_sel`=3 → from the next cycle `audioselection`=3 and the `audio_en` pattern per group is 8 on, 4 off, 8 on, 12 off. After 2 groups (64 cycles), `done`=1 for 1 cycle, `timed_out`=1, `busy`=0.
- `mode_sel`=5 → `audioselection`=0 in group 0 and 1 in group 1. It never changes while `audio_en`=1.
- `stop` on the 3rd cycle of the first ON → next cycle `audio_en`=0, `busy`=0, `done` pulse, `timed_out`=0. A `start` 1 cycle later is accepted.
- `start` while busy with a different `mode_sel`, and `start`+`stop` together in IDLE → both ignored: the pattern and `audioselection` are unchanged, and the block stays IDLE.
- `stop` in the same cycle as the final GAP expiry → `done` pulses once and `timed_out` stays 0.
- Assert `reset` mid-GAP with `timed_out` already 1 from a prior run → all outputs 0 immediately, with no `done` pulse.
